// File: rtl/fxp_alu_arbiter.sv
// fxp_alu_arbiter: round-robin sequencer that shares one combinational
// fixed-point ALU among NUM_REQ requesters and returns each result with
// the owning requester ID over a valid/ready response channel.
module fxp_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_op,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic                  alu_ctrl,
    input  logic [15:0]           alu_result,
    input  logic [3:0]            alu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_result,
    output logic                  rsp_carry,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand_id;
    logic           grant_found;
    logic           accept;

    // Only the carry bit of the ALU flags matters to the requesters.
    logic [2:0]     unused_flags;
    assign unused_flags = alu_flags[3:1];

    // Search upward from the priority pointer, wrapping, for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_id = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    // The requester after the winner gets first priority next time, wrapping at the top.
    always_comb begin
        ptr_next = grant_id + IDW'(1);
        if (grant_id == IDW'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the grant strobe is only raised while idle so a request never lands mid-operation.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept              = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    state_next          = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // Register the winner's operands and ID at accept; capture the ALU output after its evaluation cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 1'b0;
            rsp_id     <= '0;
            ptr        <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a    <= req_a[{grant_id, 4'b0000} +: 16];
                alu_b    <= req_b[{grant_id, 4'b0000} +: 16];
                alu_ctrl <= req_op[grant_id];
                rsp_id   <= grant_id;
                ptr      <= ptr_next;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_flags[0];
            end
        end
    end

endmodule
